// File: rtl/wired0_defines.sv
// Branch-prediction types shared between the PC generator and the resolve block.
// The PC generator must use these exact definitions.
package wired0_defines;

    typedef enum logic [2:0] {
        BPU_TARGET_NPC    = 3'd0,
        BPU_TARGET_IMM    = 3'd1,
        BPU_TARGET_CALL   = 3'd2,
        BPU_TARGET_RETURN = 3'd3,
        BPU_TARGET_IND    = 3'd4
    } bpu_target_type_e;

    typedef struct packed {
        logic             tid;
        logic             taken;
        logic [31:0]      predict_pc;
        logic [4:0]       lphr;
        logic [7:0]       history;
        bpu_target_type_e target_type;
        logic [1:0]       dir_type;
        logic [3:0]       ras_ptr;
    } bpu_predict_t;

    typedef struct packed {
        logic             redirect;
        logic             miss;
        logic             ras_miss_type;
        logic             need_update;
        logic             tid;
        logic [31:0]      pc;
        logic [31:0]      true_target;
        logic [31:0]      btb_target;
        logic             true_taken;
        bpu_target_type_e true_target_type;
        logic             true_conditional_jmp;
        logic [7:0]       history;
        logic [4:0]       lphr;
        logic [3:0]       ras_ptr;
    } bpu_correct_t;

endpackage

// File: rtl/wired_bpu_resolve_pkg.sv
// Helpers local to the resolve block: turns one resolved branch into the
// correction packet with miss/type-miss/update flags filled in.
package wired_bpu_resolve_pkg;
    import wired0_defines::*;

    // redirect and tid are left at 0; the caller decides them.
    function automatic bpu_correct_t resolve_pkt(
        input logic [31:0]      pc,
        input bpu_predict_t     pred,
        input logic             taken,
        input logic [31:0]      target,
        input bpu_target_type_e ttype,
        input logic             cond
    );
        bpu_correct_t p;
        p                      = '0;
        p.pc                   = pc;
        p.true_target          = taken ? target : pc + 32'd4;
        p.btb_target           = target;
        p.true_taken           = taken;
        p.true_target_type     = ttype;
        p.true_conditional_jmp = cond;
        p.history              = pred.history;
        p.lphr                 = pred.lphr;
        p.ras_ptr              = pred.ras_ptr;
        p.miss                 = (pred.taken != taken) || (taken && (pred.predict_pc != target));
        p.ras_miss_type        = (pred.target_type != ttype);
        p.need_update          = (ttype != BPU_TARGET_NPC) || (pred.target_type != BPU_TARGET_NPC);
        return p;
    endfunction

endpackage

// File: rtl/wired_bpu_resolve_if.sv
// Resolution input, correction output and flush handshake between the commit
// stage / PC generator and the resolve block.
interface wired_bpu_resolve_if;
    logic                              r_valid_i;
    logic                              r_ready_o;
    logic [31:0]                       r_pc_i;
    wired0_defines::bpu_predict_t      r_predict_i;
    logic                              r_taken_i;
    logic [31:0]                       r_target_i;
    wired0_defines::bpu_target_type_e  r_target_type_i;
    logic                              r_conditional_i;
    logic                              flush_done_i;
    wired0_defines::bpu_correct_t      p_correct_o;
    logic                              flush_o;

    modport slave (
        input  r_valid_i, r_pc_i, r_predict_i, r_taken_i, r_target_i,
               r_target_type_i, r_conditional_i, flush_done_i,
        output r_ready_o, p_correct_o, flush_o
    );

    modport master (
        output r_valid_i, r_pc_i, r_predict_i, r_taken_i, r_target_i,
               r_target_type_i, r_conditional_i, flush_done_i,
        input  r_ready_o, p_correct_o, flush_o
    );
endinterface

// File: rtl/wired_bpu_upd_fifo.sv
// Training-update FIFO of correction packets; push and pop may share a cycle,
// including when full.
module wired_bpu_upd_fifo
    import wired0_defines::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  bpu_correct_t i_data,
    input  logic         i_pop,
    output bpu_correct_t o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    bpu_correct_t  r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_do_push;
    logic          w_do_pop;

    // Extra pointer bit separates full from empty when the indices match.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/wired_bpu_resolve.sv
// Compares resolved branches with their prediction metadata and produces the
// redirect / training packet for the PC generator; owns the tier id.
module wired_bpu_resolve
    import wired0_defines::*;
    import wired_bpu_resolve_pkg::*;
#(
    parameter int   UPD_DEPTH = 4,
    parameter logic RESET_TID = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wired_bpu_resolve_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REDIR = 2'd1;
    localparam logic [1:0] S_BLOCK = 2'd2;

    logic [1:0]   r_state;
    logic         r_tid;
    bpu_correct_t r_out;

    logic         w_accept;
    logic         w_live;
    logic         w_redir;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    bpu_correct_t w_pkt;
    bpu_correct_t w_redir_pkt;
    bpu_correct_t w_upd_pkt;
    bpu_correct_t w_head;

    assign bus.r_ready_o   = rst_n && (r_state == S_IDLE) && !w_full;
    assign bus.flush_o     = (r_state == S_BLOCK);
    assign bus.p_correct_o = r_out;

    assign w_accept = bus.r_valid_i && bus.r_ready_o;
    assign w_live   = w_accept && (bus.r_predict_i.tid == r_tid);
    assign w_pkt    = resolve_pkt(bus.r_pc_i, bus.r_predict_i, bus.r_taken_i,
                                  bus.r_target_i, bus.r_target_type_i, bus.r_conditional_i);
    assign w_redir  = w_live && (w_pkt.miss || w_pkt.ras_miss_type);
    assign w_push   = w_live && w_pkt.need_update && !w_redir;
    // A redirect owns the output slot; the queue head waits a cycle.
    assign w_pop    = !w_empty && !w_redir;

    always_comb begin
        w_redir_pkt          = w_pkt;
        w_redir_pkt.redirect = 1'b1;
        w_redir_pkt.tid      = ~r_tid;

        w_upd_pkt               = w_pkt;
        w_upd_pkt.redirect      = 1'b0;
        w_upd_pkt.miss          = 1'b0;
        w_upd_pkt.ras_miss_type = 1'b0;
        w_upd_pkt.need_update   = 1'b1;
        w_upd_pkt.tid           = r_tid;
    end

    wired_bpu_upd_fifo #(.DEPTH(UPD_DEPTH)) u_upd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_upd_pkt),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (w_redir) begin
            r_out <= w_redir_pkt;
        end else if (w_pop) begin
            r_out <= w_head;
        end else begin
            r_out <= '0;
        end
    end

    // tid flips on the edge that presents the redirect, so the packet and
    // tid_q agree during that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tid   <= RESET_TID;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_redir) begin
                        r_state <= S_REDIR;
                        r_tid   <= ~r_tid;
                    end
                end
                S_REDIR: r_state <= S_BLOCK;
                S_BLOCK: if (bus.flush_done_i) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wired_bpu_resolve.sv
// Randomized and directed bench for wired_bpu_resolve against a queue-based
// transaction model of the correction protocol.
module tb_wired_bpu_resolve;
    import wired0_defines::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wired_bpu_resolve_if bus();

    wired_bpu_resolve #(.UPD_DEPTH(DEPTH), .RESET_TID(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int           checks = 0;
    int           errors = 0;
    int           m_mode;            // 0 accepting, 1 redirect shown, 2 awaiting flush
    bit           m_tid;
    bpu_correct_t m_q[$];
    bpu_correct_t m_out;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit m_ready();
        return (m_mode == 0) && (m_q.size() < DEPTH);
    endfunction

    task automatic compare_all();
        chk("ready", 256'(bus.r_ready_o), 256'(m_ready()));
        chk("flush", 256'(bus.flush_o), 256'(m_mode == 2));
        chk("packet", 256'(bus.p_correct_o), 256'(m_out));
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_tid  = 1'b0;
        m_q.delete();
        m_out  = '0;
    endtask

    function automatic bpu_predict_t mk_pred(input bit tid, input bit tk, input logic [31:0] ppc,
                                             input bpu_target_type_e tt, input logic [3:0] ras);
        bpu_predict_t p;
        p             = '0;
        p.tid         = tid;
        p.taken       = tk;
        p.predict_pc  = ppc;
        p.target_type = tt;
        p.ras_ptr     = ras;
        p.history     = 8'h5A;
        p.lphr        = 5'h13;
        return p;
    endfunction

    // Drive one cycle of inputs, advance the model by one clock, compare.
    task automatic drive(input bit v, input logic [31:0] pc, input bpu_predict_t pred,
                         input bit tk, input logic [31:0] tgt, input bpu_target_type_e tt,
                         input bit cond, input bit fdone);
        bit           redir;
        bit           push;
        bpu_correct_t pkt;
        bpu_correct_t nxt;
        bus.r_valid_i       = v;
        bus.r_pc_i          = pc;
        bus.r_predict_i     = pred;
        bus.r_taken_i       = tk;
        bus.r_target_i      = tgt;
        bus.r_target_type_i = tt;
        bus.r_conditional_i = cond;
        bus.flush_done_i    = fdone;

        redir = 0;
        push  = 0;
        pkt   = '0;
        if (v && m_ready() && pred.tid == m_tid) begin
            pkt.pc                   = pc;
            pkt.true_target          = tk ? tgt : pc + 32'd4;
            pkt.btb_target           = tgt;
            pkt.true_taken           = tk;
            pkt.true_target_type     = tt;
            pkt.true_conditional_jmp = cond;
            pkt.history              = pred.history;
            pkt.lphr                 = pred.lphr;
            pkt.ras_ptr              = pred.ras_ptr;
            pkt.miss          = (pred.taken != tk) || (tk && pred.predict_pc != tgt);
            pkt.ras_miss_type = pred.target_type != tt;
            pkt.need_update   = (tt != BPU_TARGET_NPC) || (pred.target_type != BPU_TARGET_NPC);
            if (pkt.miss || pkt.ras_miss_type) redir = 1;
            else if (pkt.need_update) push = 1;
        end

        if (redir) begin
            nxt          = pkt;
            nxt.redirect = 1'b1;
            nxt.tid      = ~m_tid;
        end else if (m_q.size() > 0) begin
            nxt = m_q.pop_front();
        end else begin
            nxt = '0;
        end
        if (push) begin
            pkt.tid = m_tid;
            m_q.push_back(pkt);
        end
        m_out = nxt;

        case (m_mode)
            0: if (redir) begin m_mode = 1; m_tid = ~m_tid; end
            1: m_mode = 2;
            default: if (fdone) m_mode = 0;
        endcase

        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input bit fdone);
        drive(0, '0, '0, 0, '0, BPU_TARGET_NPC, 0, fdone);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.r_valid_i = 1'b0;
        bus.flush_done_i = 1'b0;
        #1;
        chk("rst_packet", 256'(bus.p_correct_o), 256'(0));
        chk("rst_ready", 256'(bus.r_ready_o), 256'(0));
        chk("rst_flush", 256'(bus.flush_o), 256'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.r_valid_i       = 1'b0;
        bus.r_pc_i          = '0;
        bus.r_predict_i     = '0;
        bus.r_taken_i       = 1'b0;
        bus.r_target_i      = '0;
        bus.r_target_type_i = BPU_TARGET_NPC;
        bus.r_conditional_i = 1'b0;
        bus.flush_done_i    = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();
        idle(0);

        // Correct taken IMM -> one update packet, no flush.
        drive(1, 32'h1c000010, mk_pred(0, 1, 32'h1c000100, BPU_TARGET_IMM, 4'h2),
              1, 32'h1c000100, BPU_TARGET_IMM, 0, 0);
        idle(0);
        chk("upd_redirect", 256'(bus.p_correct_o.redirect), 256'(0));
        chk("upd_need", 256'(bus.p_correct_o.need_update), 256'(1));
        chk("upd_btb", 256'(bus.p_correct_o.btb_target), 256'(32'h1c000100));
        chk("upd_flush", 256'(bus.flush_o), 256'(0));

        // Direction mispredict -> redirect, tid 1, flush until done.
        drive(1, 32'h1c000020, mk_pred(0, 0, 32'h0, BPU_TARGET_IMM, 4'h3),
              1, 32'h1c000200, BPU_TARGET_IMM, 1, 0);
        chk("mis_redirect", 256'(bus.p_correct_o.redirect), 256'(1));
        chk("mis_miss", 256'(bus.p_correct_o.miss), 256'(1));
        chk("mis_target", 256'(bus.p_correct_o.true_target), 256'(32'h1c000200));
        chk("mis_tid", 256'(bus.p_correct_o.tid), 256'(1));
        chk("mis_ready", 256'(bus.r_ready_o), 256'(0));
        idle(0);
        chk("mis_flush", 256'(bus.flush_o), 256'(1));
        chk("mis_pkt_gone", 256'(bus.p_correct_o.redirect), 256'(0));
        idle(0);
        idle(1);
        chk("mis_flush_drop", 256'(bus.flush_o), 256'(0));
        chk("mis_ready_back", 256'(bus.r_ready_o), 256'(1));

        // Stale tid 0 after the redirect -> ignored.
        drive(1, 32'h1c000030, mk_pred(0, 0, 32'h0, BPU_TARGET_IMM, 4'h0),
              1, 32'h1c000300, BPU_TARGET_CALL, 0, 0);
        chk("stale_pkt", 256'(bus.p_correct_o), 256'(0));
        chk("stale_ready", 256'(bus.r_ready_o), 256'(1));
        idle(0);

        // Type miss only: predicted IMM, actual CALL, same target.
        drive(1, 32'h1c000040, mk_pred(1, 1, 32'h1c000400, BPU_TARGET_IMM, 4'h5),
              1, 32'h1c000400, BPU_TARGET_CALL, 0, 0);
        chk("tm_redirect", 256'(bus.p_correct_o.redirect), 256'(1));
        chk("tm_miss", 256'(bus.p_correct_o.miss), 256'(0));
        chk("tm_rasmiss", 256'(bus.p_correct_o.ras_miss_type), 256'(1));
        chk("tm_rasptr", 256'(bus.p_correct_o.ras_ptr), 256'(4'h5));
        chk("tm_tid", 256'(bus.p_correct_o.tid), 256'(0));
        idle(0);
        idle(1);

        // Not-taken at top of address space wraps to 0.
        drive(1, 32'hFFFFFFFC, mk_pred(0, 0, 32'h0, BPU_TARGET_IMM, 4'h1),
              0, 32'h00001000, BPU_TARGET_IMM, 1, 0);
        idle(0);
        chk("wrap_target", 256'(bus.p_correct_o.true_target), 256'(0));
        chk("wrap_need", 256'(bus.p_correct_o.need_update), 256'(1));

        // Back-to-back updates then a redirect; queue drains in order.
        for (int i = 0; i < 4; i++)
            drive(1, 32'h1c001000 + 32'(i*4), mk_pred(0, 1, 32'h1c002000 + 32'(i*16), BPU_TARGET_IMM, 4'(i)),
                  1, 32'h1c002000 + 32'(i*16), BPU_TARGET_IMM, 1, 0);
        drive(1, 32'h1c001010, mk_pred(0, 1, 32'h1c003000, BPU_TARGET_RETURN, 4'h7),
              1, 32'h1c003300, BPU_TARGET_RETURN, 0, 0);
        chk("bp_redirect", 256'(bus.p_correct_o.redirect), 256'(1));
        idle(0);
        chk("bp_head_after", 256'(bus.p_correct_o.btb_target), 256'(32'h1c002030));
        idle(0);
        idle(1);

        // Reset in the middle of traffic with a queued update.
        drive(1, 32'h1c004000, mk_pred(1, 1, 32'h1c004100, BPU_TARGET_IMM, 4'h0),
              1, 32'h1c004100, BPU_TARGET_IMM, 1, 0);
        drive(1, 32'h1c004004, mk_pred(1, 0, 32'h0, BPU_TARGET_IMM, 4'h0),
              1, 32'h1c004200, BPU_TARGET_IMM, 1, 0);
        do_reset();
        for (int i = 0; i < 3; i++) idle(0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0]      pc;
            logic [31:0]      tgt;
            bit               tk;
            bpu_target_type_e tt;
            bpu_predict_t     pr;
            pc  = $urandom & 32'hFFFFFFFC;
            if ($urandom_range(0, 15) == 0) pc = 32'hFFFFFFFC;
            tgt = $urandom & 32'hFFFFFFFC;
            tk  = $urandom_range(0, 1);
            tt  = bpu_target_type_e'($urandom_range(0, 4));
            if ($urandom_range(0, 2) == 0) tt = BPU_TARGET_NPC;
            pr = '0;
            pr.tid         = ($urandom_range(0, 7) == 0) ? ~m_tid : m_tid;
            pr.taken       = ($urandom_range(0, 4) == 0) ? ~tk : tk;
            pr.predict_pc  = ($urandom_range(0, 5) == 0) ? ($urandom & 32'hFFFFFFFC) : tgt;
            pr.target_type = ($urandom_range(0, 4) == 0) ? bpu_target_type_e'($urandom_range(0, 4)) : tt;
            pr.lphr        = 5'($urandom);
            pr.history     = 8'($urandom);
            pr.dir_type    = 2'($urandom);
            pr.ras_ptr     = 4'($urandom);
            drive($urandom_range(0, 9) < 7, pc, pr, tk, tgt, tt, 1'($urandom),
                  $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
